// File: rtl/hazard_scoreboard.sv
// Stall/forward controller for an in-order pipeline driven by pre-decoded Tuse/Tnew fields.
// Tracks in-flight destinations with a Tnew countdown and interlocks HI/LO readers behind a busy MDU.
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int NSTAGE  = 3,
  parameter int TW      = 2,
  parameter int MDU_LAT = 5,
  parameter int SELW    = $clog2(NSTAGE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic [REG_AW-1:0] d_waddr,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_use,
  output logic              stall,
  output logic [SELW-1:0]   d_fwd_rs,
  output logic [SELW-1:0]   d_fwd_rt,
  output logic [SELW-1:0]   e_fwd_rs,
  output logic [SELW-1:0]   e_fwd_rt
);

  localparam int CW = 4;
  localparam logic [CW-1:0] MDU_LOAD = CW'(MDU_LAT);

  typedef struct packed {
    logic            hit;
    logic [SELW-1:0] sel;
    logic [TW-1:0]   tnew;
  } match_t;

  // Index 1 is E, index NSTAGE is W; source registers and the MDU flag only matter in E.
  logic [NSTAGE:1][REG_AW-1:0] waddr_r;
  logic [NSTAGE:1][TW-1:0]     tnew_r;
  logic [REG_AW-1:0]           e_rs_r;
  logic [REG_AW-1:0]           e_rt_r;
  logic                        e_md_r;
  logic [CW-1:0]               mdu_cnt_r;

  match_t d_rs_m_s;
  match_t d_rt_m_s;
  match_t e_rs_m_s;
  match_t e_rt_m_s;
  logic   md_block_s;
  logic   stall_s;
  logic   issue_s;

  // Walk oldest to youngest so the youngest hit overwrites any older one.
  function automatic match_t youngest_match(
    input logic [REG_AW-1:0]           addr,
    input int                          first,
    input logic [NSTAGE:1][REG_AW-1:0] waddr,
    input logic [NSTAGE:1][TW-1:0]     tnew
  );
    match_t m;
    logic   hit;
    m = '0;
    for (int s = NSTAGE; s >= 1; s--) begin
      hit = (s >= first) && (addr != '0) && (waddr[s] == addr);
      m   = hit ? {1'b1, SELW'(s), tnew[s]} : m;
    end
    return m;
  endfunction

  function automatic logic [SELW-1:0] fwd_sel(input match_t m);
    return (m.hit && (m.tnew == '0)) ? m.sel : '0;
  endfunction

  // Operand matching and the D-stage stall decision.
  always_comb begin
    d_rs_m_s   = youngest_match(d_rs, 1, waddr_r, tnew_r);
    d_rt_m_s   = youngest_match(d_rt, 1, waddr_r, tnew_r);
    e_rs_m_s   = youngest_match(e_rs_r, 2, waddr_r, tnew_r);
    e_rt_m_s   = youngest_match(e_rt_r, 2, waddr_r, tnew_r);
    md_block_s = d_md_use && ((mdu_cnt_r != '0) || e_md_r);
    stall_s    = d_valid && ((d_rs_m_s.hit && (d_rs_m_s.tnew > d_tuse_rs)) ||
                             (d_rt_m_s.hit && (d_rt_m_s.tnew > d_tuse_rt)) ||
                             md_block_s);
    issue_s    = d_valid && !stall_s;
  end

  // Output drive; everything reads as idle while reset is held.
  always_comb begin
    stall    = 1'b0;
    d_fwd_rs = '0;
    d_fwd_rt = '0;
    e_fwd_rs = '0;
    e_fwd_rt = '0;
    if (reset) begin
      stall = 1'b0;
    end else begin
      stall    = stall_s;
      d_fwd_rs = fwd_sel(d_rs_m_s);
      d_fwd_rt = fwd_sel(d_rt_m_s);
      e_fwd_rs = fwd_sel(e_rs_m_s);
      e_fwd_rt = fwd_sel(e_rt_m_s);
    end
  end

  // Pipeline advance with saturating Tnew countdown, plus the MDU busy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      waddr_r   <= '0;
      tnew_r    <= '0;
      e_rs_r    <= '0;
      e_rt_r    <= '0;
      e_md_r    <= 1'b0;
      mdu_cnt_r <= '0;
    end else begin
      for (int s = NSTAGE; s >= 2; s--) begin
        waddr_r[s] <= waddr_r[s-1];
        tnew_r[s]  <= (tnew_r[s-1] == '0) ? '0 : tnew_r[s-1] - 1'b1;
      end
      if (issue_s) begin
        waddr_r[1] <= d_waddr;
        tnew_r[1]  <= d_tnew;
        e_rs_r     <= d_rs;
        e_rt_r     <= d_rt;
        e_md_r     <= d_md_start;
      end else begin
        waddr_r[1] <= '0;
        tnew_r[1]  <= '0;
        e_rs_r     <= '0;
        e_rt_r     <= '0;
        e_md_r     <= 1'b0;
      end
      if (e_md_r) begin
        mdu_cnt_r <= MDU_LOAD;
      end else if (mdu_cnt_r != '0) begin
        mdu_cnt_r <= mdu_cnt_r - 1'b1;
      end else begin
        mdu_cnt_r <= mdu_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomised checks of hazard_scoreboard against a queue-based model that
// tracks each issued instruction by the cycle it entered E.
module tb_hazard_scoreboard;

  localparam int REG_AW  = 5;
  localparam int NSTAGE  = 3;
  localparam int TW      = 2;
  localparam int MDU_LAT = 5;
  localparam int SELW    = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              d_valid;
  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [TW-1:0]     d_tuse_rs;
  logic [TW-1:0]     d_tuse_rt;
  logic [REG_AW-1:0] d_waddr;
  logic [TW-1:0]     d_tnew;
  logic              d_md_start;
  logic              d_md_use;
  logic              stall;
  logic [SELW-1:0]   d_fwd_rs;
  logic [SELW-1:0]   d_fwd_rt;
  logic [SELW-1:0]   e_fwd_rs;
  logic [SELW-1:0]   e_fwd_rt;

  hazard_scoreboard #(
    .REG_AW(REG_AW), .NSTAGE(NSTAGE), .TW(TW), .MDU_LAT(MDU_LAT), .SELW(SELW)
  ) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_waddr(d_waddr), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_use(d_md_use), .stall(stall),
    .d_fwd_rs(d_fwd_rs), .d_fwd_rt(d_fwd_rt), .e_fwd_rs(e_fwd_rs), .e_fwd_rt(e_fwd_rt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int waddr;
    int tnew;
    int rs;
    int rt;
    int e_cyc;
  } instr_t;

  instr_t q[$];
  int now_cyc = 0;
  int md_cyc  = -100;
  int checks  = 0;
  int passed  = 0;
  int failed  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Age in the current cycle: 1 = E, NSTAGE = W.
  function automatic int age_of(input int e_cyc);
    return now_cyc - e_cyc + 1;
  endfunction

  function automatic int rem_tnew(input int tnew, input int age);
    return (tnew > age - 1) ? tnew - (age - 1) : 0;
  endfunction

  function automatic void find(input int addr, input int min_age, output int age, output int rem);
    int a;
    age = 0;
    rem = 0;
    if (addr != 0) begin
      foreach (q[i]) begin
        a = age_of(q[i].e_cyc);
        if (q[i].waddr == addr && a >= min_age && a <= NSTAGE && (age == 0 || a < age)) begin
          age = a;
          rem = rem_tnew(q[i].tnew, a);
        end
      end
    end
  endfunction

  function automatic int rem_at(input int addr, input int age);
    foreach (q[i]) begin
      if (age_of(q[i].e_cyc) == age && q[i].waddr == addr) return rem_tnew(q[i].tnew, age);
    end
    return -1;
  endfunction

  function automatic int e_operand(input bit want_rt);
    foreach (q[i]) begin
      if (age_of(q[i].e_cyc) == 1) return want_rt ? q[i].rt : q[i].rs;
    end
    return 0;
  endfunction

  function automatic bit md_busy();
    return (now_cyc - md_cyc) >= 0 && (now_cyc - md_cyc) <= MDU_LAT;
  endfunction

  function automatic bit model_stall();
    int a;
    int r;
    bit s;
    s = 1'b0;
    if (d_valid) begin
      find(int'(d_rs), 1, a, r);
      if (a != 0 && r > int'(d_tuse_rs)) s = 1'b1;
      find(int'(d_rt), 1, a, r);
      if (a != 0 && r > int'(d_tuse_rt)) s = 1'b1;
      if (d_md_use && md_busy()) s = 1'b1;
    end
    return s;
  endfunction

  function automatic int model_fwd(input int addr, input int min_age);
    int a;
    int r;
    find(addr, min_age, a, r);
    return (a != 0 && r == 0) ? a : 0;
  endfunction

  task automatic check_model(input string tag);
    int xs, xdrs, xdrt, xers, xert;
    xs = 0; xdrs = 0; xdrt = 0; xers = 0; xert = 0;
    if (!reset) begin
      xs   = int'(model_stall());
      xdrs = model_fwd(int'(d_rs), 1);
      xdrt = model_fwd(int'(d_rt), 1);
      xers = model_fwd(e_operand(1'b0), 2);
      xert = model_fwd(e_operand(1'b1), 2);
    end
    chk({tag, "_stall"}, stall, xs);
    chk({tag, "_d_fwd_rs"}, d_fwd_rs, xdrs);
    chk({tag, "_d_fwd_rt"}, d_fwd_rt, xdrt);
    chk({tag, "_e_fwd_rs"}, e_fwd_rs, xers);
    chk({tag, "_e_fwd_rt"}, e_fwd_rt, xert);
    if (e_fwd_rs !== '0) chk({tag, "_e_rs_ready"}, rem_at(e_operand(1'b0), int'(e_fwd_rs)), 0);
    if (e_fwd_rt !== '0) chk({tag, "_e_rt_ready"}, rem_at(e_operand(1'b1), int'(e_fwd_rt)), 0);
  endtask

  // Update the model from the inputs seen at the coming edge, then clock.
  task automatic advance();
    bit st;
    instr_t it;
    st = model_stall();
    if (reset) begin
      q.delete();
      md_cyc = -100;
    end else if (d_valid && !st) begin
      it.waddr = int'(d_waddr);
      it.tnew  = int'(d_tnew);
      it.rs    = int'(d_rs);
      it.rt    = int'(d_rt);
      it.e_cyc = now_cyc + 1;
      q.push_back(it);
      if (d_md_start) md_cyc = now_cyc + 1;
    end
    @(posedge clk);
    now_cyc++;
    while (q.size() > 0 && age_of(q[0].e_cyc) > NSTAGE) void'(q.pop_front());
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input int rs, input int tuse_rs, input int rt, input int tuse_rt,
                       input int waddr, input int tnew, input bit mds, input bit mdu);
    d_valid    = v;
    d_rs       = REG_AW'(rs);
    d_tuse_rs  = TW'(tuse_rs);
    d_rt       = REG_AW'(rt);
    d_tuse_rt  = TW'(tuse_rt);
    d_waddr    = REG_AW'(waddr);
    d_tnew     = TW'(tnew);
    d_md_start = mds;
    d_md_use   = mdu;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      #1;
      advance();
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    drive(1'b1, 1, 0, 1, 0, 1, 0, 1'b1, 1'b1);
    @(negedge clk);

    // Outputs forced low while reset is held, even with hazard-looking D inputs.
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_d_fwd_rs", d_fwd_rs, 0);
    chk("rst_d_fwd_rt", d_fwd_rt, 0);
    chk("rst_e_fwd_rs", e_fwd_rs, 0);
    chk("rst_e_fwd_rt", e_fwd_rt, 0);
    advance();
    advance();
    reset = 1'b0;

    // Test 1: ready producer in E forwards to D.
    drive(1'b1, 0, 0, 0, 0, 1, 0, 1'b0, 1'b0);
    #1;
    chk("t1_issue_stall", stall, 0);
    advance();
    drive(1'b1, 1, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    #1;
    chk("t1_stall", stall, 0);
    chk("t1_d_fwd_rs", d_fwd_rs, 1);
    chk("t1_d_fwd_rt", d_fwd_rt, 0);
    advance();
    idle(4);

    // Test 2: load-use stall for one cycle, then E-stage forward from W.
    drive(1'b1, 0, 0, 0, 0, 1, 2, 1'b0, 1'b0);
    #1;
    advance();
    drive(1'b1, 0, 0, 1, 1, 0, 0, 1'b0, 1'b0);
    #1;
    chk("t2_stall", stall, 1);
    chk("t2_d_fwd_rt_wait", d_fwd_rt, 0);
    d_valid = 1'b0;
    #1;
    chk("t2_novalid_stall", stall, 0);
    d_valid = 1'b1;
    #1;
    advance();
    #1;
    chk("t2_release_stall", stall, 0);
    chk("t2_release_d_fwd_rt", d_fwd_rt, 0);
    advance();
    drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    #1;
    chk("t2_e_fwd_rt", e_fwd_rt, 3);
    chk("t2_e_fwd_rs", e_fwd_rs, 0);
    advance();
    idle(4);

    // Test 3: youngest match wins; rs == rt gives identical selects; address 0 never matches.
    drive(1'b1, 0, 0, 0, 0, 2, 0, 1'b0, 1'b0);
    #1;
    advance();
    drive(1'b1, 0, 0, 0, 0, 2, 0, 1'b0, 1'b0);
    #1;
    advance();
    drive(1'b1, 2, 0, 2, 0, 0, 0, 1'b0, 1'b0);
    #1;
    chk("t3_d_fwd_rs", d_fwd_rs, 1);
    chk("t3_d_fwd_rt", d_fwd_rt, 1);
    chk("t3_stall", stall, 0);
    d_rs = '0;
    #1;
    chk("t3_rs0_d_fwd_rs", d_fwd_rs, 0);
    chk("t3_rs0_stall", stall, 0);
    advance();
    idle(4);
    drive(1'b1, 0, 0, 0, 0, 0, 3, 1'b0, 1'b0);
    #1;
    advance();
    drive(1'b1, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    #1;
    chk("t3_waddr0_stall", stall, 0);
    chk("t3_waddr0_d_fwd_rs", d_fwd_rs, 0);
    advance();
    idle(4);

    // Test 4: mfhi behind a mult stalls for exactly 1 + MDU_LAT cycles.
    drive(1'b1, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    #1;
    chk("t4_mult_stall", stall, 0);
    advance();
    drive(1'b1, 0, 0, 0, 0, 3, 1, 1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (stall !== 1'b1) break;
      n++;
      advance();
    end
    chk("t4_stall_cycles", n, 1 + MDU_LAT);
    advance();
    idle(4);

    // Test 5: reset during a load-use stall drops all in-flight state.
    drive(1'b1, 0, 0, 0, 0, 1, 2, 1'b0, 1'b0);
    #1;
    advance();
    drive(1'b1, 0, 0, 1, 1, 0, 0, 1'b0, 1'b0);
    #1;
    chk("t5_pre_stall", stall, 1);
    reset = 1'b1;
    #1;
    chk("t5_in_reset_stall", stall, 0);
    advance();
    reset = 1'b0;
    #1;
    chk("t5_post_stall", stall, 0);
    chk("t5_post_d_fwd_rs", d_fwd_rs, 0);
    chk("t5_post_d_fwd_rt", d_fwd_rt, 0);
    chk("t5_post_e_fwd_rs", e_fwd_rs, 0);
    chk("t5_post_e_fwd_rt", e_fwd_rt, 0);
    advance();

    // Test 6: randomised instruction stream against the model.
    for (int i = 0; i < 600; i++) begin
      bit mds;
      reset = ($urandom_range(0, 149) == 0);
      mds = ($urandom_range(0, 11) == 0);
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3),
            mds, mds | ($urandom_range(0, 7) == 0));
      #1;
      check_model("rnd");
      advance();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
